wb_commit_stage: RTL



---
 rtl/wb_commit_stage.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_commit_stage.sv
// wb_commit_stage: write-back/commit stage; commits GPR/CSR writes, exceptions and ERTN, counts retirements.
// Latency: an instruction accepted at edge N commits in cycle N+1 unless stalled; trace entries appear one cycle after commit.
// Backpressure: a full trace FIFO stalls only GPR-writing commits (in_allowin=0); exceptions and ERTN are never stalled.
//
// Optional feature macro: WB_TRACE_FIFO_EN (trace leaves through a back-pressured FIFO; otherwise trace is a
// combinational copy of the GPR commit and trace_ready is ignored).
//
// Ports:
//   clk/resetn                       clock, synchronous active-low reset
//   in_valid/in_allowin              MEM -> WB handshake
//   in_*                             instruction payload from MEM
//   rf_we/rf_waddr/rf_wdata          GPR write port
//   fwd_dest/fwd_from_mem/fwd_data   forwarding bus (driven while stalled)
//   csr_we/csr_num/csr_wvalue/mask   CSR write port
//   wb_ex/wb_ecode/wb_esubcode/wb_pc exception report; ertn_flush front-end flush
//   retire_cnt                       64-bit committed-instruction counter
//   trace_valid/trace_ready/trace_*  debug trace handshake and payload

`ifdef WB_TRACE_FIFO_EN
// wb_trace_fifo: generic single-clock FIFO with pointer-based full/empty.
// Latency: a pushed entry is visible on pop_vld/pop_dat the cycle after the push.
// Backpressure: push_rdy is low while full (registered state only, a same-cycle pop does not help).
module wb_trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic             full, empty, do_push, do_pop;

  always_comb begin
    // Extra pointer MSB differs only when the writer has lapped the reader.
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    push_rdy = !full;
    pop_vld  = !empty;
    do_push  = push_vld && !full;
    do_pop   = pop_rdy && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
    end
    pop_dat  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: readers only look at it through pop_vld.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule
`endif

module wb_commit_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int CSR_AW      = 14,
  parameter int TRACE_DEPTH = 4,
  parameter int ECODE_W     = 6,
  parameter int ESUB_W      = 9
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_allowin,
  input  logic [DATA_W-1:0]  in_pc,
  input  logic               in_gr_we,
  input  logic [REG_AW-1:0]  in_dest,
  input  logic [DATA_W-1:0]  in_mem_result,
  input  logic [DATA_W-1:0]  in_alu_result,
  input  logic               in_rfrom_mem,
  input  logic               in_csr_we,
  input  logic [CSR_AW-1:0]  in_csr_num,
  input  logic [DATA_W-1:0]  in_csr_wvalue,
  input  logic [DATA_W-1:0]  in_csr_wmask,
  input  logic               in_ex,
  input  logic [ECODE_W-1:0] in_ecode,
  input  logic [ESUB_W-1:0]  in_esubcode,
  input  logic               in_ertn,
  output logic               rf_we,
  output logic [REG_AW-1:0]  rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [REG_AW-1:0]  fwd_dest,
  output logic               fwd_from_mem,
  output logic [DATA_W-1:0]  fwd_data,
  output logic               csr_we,
  output logic [CSR_AW-1:0]  csr_num,
  output logic [DATA_W-1:0]  csr_wvalue,
  output logic [DATA_W-1:0]  csr_wmask,
  output logic               wb_ex,
  output logic [ECODE_W-1:0] wb_ecode,
  output logic [ESUB_W-1:0]  wb_esubcode,
  output logic [DATA_W-1:0]  wb_pc,
  output logic               ertn_flush,
  output logic [63:0]        retire_cnt,
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic [DATA_W-1:0]  trace_pc,
  output logic [3:0]         trace_we,
  output logic [REG_AW-1:0]  trace_wnum,
  output logic [DATA_W-1:0]  trace_wdata
);
  typedef struct packed {
    logic [DATA_W-1:0]  pc;
    logic               gr_we;
    logic [REG_AW-1:0]  dest;
    logic [DATA_W-1:0]  mem_result;
    logic [DATA_W-1:0]  alu_result;
    logic               rfrom_mem;
    logic               csr_we;
    logic [CSR_AW-1:0]  csr_num;
    logic [DATA_W-1:0]  csr_wvalue;
    logic [DATA_W-1:0]  csr_wmask;
    logic               ex;
    logic [ECODE_W-1:0] ecode;
    logic [ESUB_W-1:0]  esubcode;
    logic               ertn;
  } stage_t;

  stage_t            st_q, st_d;
  logic              valid_q, valid_d;
  logic [63:0]       retire_cnt_q, retire_cnt_d;
  logic [DATA_W-1:0] result;
  logic              need_push, ready_go, commit, retire_ok;

  always_comb begin
    result     = st_q.rfrom_mem ? st_q.mem_result : st_q.alu_result;
    need_push  = valid_q && st_q.gr_we && !st_q.ex && !st_q.ertn;
    commit     = valid_q && ready_go;
    retire_ok  = !st_q.ex && !st_q.ertn;
    in_allowin = !valid_q || ready_go;

    rf_we      = commit && st_q.gr_we && retire_ok;
    rf_waddr   = st_q.dest;
    rf_wdata   = result;

    csr_we     = commit && st_q.csr_we && retire_ok;
    csr_num    = st_q.csr_num;
    csr_wvalue = st_q.csr_wvalue;
    csr_wmask  = st_q.csr_wmask;

    // Exception/ERTN do not need the FIFO, so they ignore ready_go.
    wb_ex       = valid_q && st_q.ex;
    ertn_flush  = valid_q && st_q.ertn && !st_q.ex;
    wb_ecode    = st_q.ecode;
    wb_esubcode = st_q.esubcode;
    wb_pc       = st_q.pc;

    fwd_dest     = (valid_q && st_q.gr_we) ? st_q.dest : '0;
    fwd_from_mem = st_q.rfrom_mem;
    fwd_data     = result;

    retire_cnt = retire_cnt_q;
  end

  always_comb begin
    st_d = st_q;
    if (in_valid && in_allowin) begin
      st_d.pc         = in_pc;
      st_d.gr_we      = in_gr_we;
      st_d.dest       = in_dest;
      st_d.mem_result = in_mem_result;
      st_d.alu_result = in_alu_result;
      st_d.rfrom_mem  = in_rfrom_mem;
      st_d.csr_we     = in_csr_we;
      st_d.csr_num    = in_csr_num;
      st_d.csr_wvalue = in_csr_wvalue;
      st_d.csr_wmask  = in_csr_wmask;
      st_d.ex         = in_ex;
      st_d.ecode      = in_ecode;
      st_d.esubcode   = in_esubcode;
      st_d.ertn       = in_ertn;
    end

    // A flush also discards whatever MEM offers in the same cycle.
    valid_d = valid_q;
    if (wb_ex || ertn_flush) begin
      valid_d = 1'b0;
    end else if (in_allowin) begin
      valid_d = in_valid;
    end

    // ERTN retires; an excepting instruction does not.
    retire_cnt_d = retire_cnt_q;
    if (commit && !st_q.ex) begin
      retire_cnt_d = retire_cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q      <= 1'b0;
      st_q         <= '0;
      retire_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      st_q         <= st_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

`ifdef WB_TRACE_FIFO_EN
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] wnum;
    logic [DATA_W-1:0] wdata;
  } trace_ent_t;

  trace_ent_t trace_push_dat, trace_pop_dat;
  logic       trace_push_rdy, trace_pop_vld;

  always_comb begin
    trace_push_dat.pc    = st_q.pc;
    trace_push_dat.wnum  = st_q.dest;
    trace_push_dat.wdata = result;
    ready_go             = !(need_push && !trace_push_rdy);
    // Payload is zeroed while empty so stale storage never leaks out.
    trace_valid = trace_pop_vld;
    trace_pc    = trace_pop_vld ? trace_pop_dat.pc    : '0;
    trace_wnum  = trace_pop_vld ? trace_pop_dat.wnum  : '0;
    trace_wdata = trace_pop_vld ? trace_pop_dat.wdata : '0;
    trace_we    = {4{trace_valid}};
  end

  wb_trace_fifo #(
    .W     ($bits(trace_ent_t)),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push_vld (rf_we),
    .push_dat (trace_push_dat),
    .push_rdy (trace_push_rdy),
    .pop_vld  (trace_pop_vld),
    .pop_rdy  (trace_ready),
    .pop_dat  (trace_pop_dat)
  );
`else
  logic unused_trace;

  always_comb begin
    ready_go     = 1'b1;
    unused_trace = trace_ready | need_push;
    trace_valid  = rf_we;
    trace_pc     = st_q.pc;
    trace_wnum   = st_q.dest;
    trace_wdata  = result;
    trace_we     = {4{trace_valid}};
  end
`endif

endmodule
